load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// the default load-data timeout and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        if (write) return !(f3 inside {F3_B, F3_H, F3_W});
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    // Only meaningful for legal encodings; bits [1:0] give the access size.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication / byte enables and
// load lane selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_be,
    output logic [31:0] load_result
);

    logic [31:0] shifted;

    assign shifted = load_word >> {addr_lo, 3'b000};

    always_comb begin
        lane_wdata = store_data;
        lane_be    = 4'b1111;
        if (is_write) begin
            case (funct3)
                F3_B: begin
                    lane_wdata = {4{store_data[7:0]}};
                    lane_be    = 4'b0001 << addr_lo;
                end
                F3_H: begin
                    lane_wdata = {2{store_data[15:0]}};
                    lane_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            F3_B:    load_result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_result = {24'h0, shifted[7:0]};
            F3_HU:   load_result = {16'h0, shifted[15:0]};
            default: load_result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a word memory.
// Optional load-data timeout is enabled with the LSU_TIMEOUT_EN macro.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [31:0]       write_data,
    output logic              rsp_valid,
    output logic [31:0]       read_data,
    output logic              misaligned,
    output logic              illegal,
    output logic              timeout,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the initiator holds valid and its payload stable until that edge.
    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_q;
    logic              mis_q, ill_q, to_q;

    logic              accept, req_ill, req_mis;
    logic              res_load, res_mis, res_ill, res_to;
    logic [31:0]       res_data;
    logic              in_access, wait_expired;
    logic [31:0]       lane_wdata, load_result;
    logic [3:0]        lane_be;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign req_ill = f3_illegal(req_write, req_funct3);
    assign req_mis = !req_ill && f3_misaligned(req_funct3, ALUResult[1:0]);

    lsu_align u_align (
        .funct3      (f3_q),
        .is_write    (write_q),
        .addr_lo     (addr_q[1:0]),
        .store_data  (wdata_q),
        .load_word   (mem_rdata),
        .lane_wdata  (lane_wdata),
        .lane_be     (lane_be),
        .load_result (load_result)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt_q <= '0;
        else if (state_q != ST_WAIT_R) cnt_q <= '0;
        else if (!mem_rvalid)          cnt_q <= cnt_q + 1'b1;
    end

    assign wait_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign wait_expired       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        res_load = 1'b0;
        res_data = 32'h0;
        res_mis  = 1'b0;
        res_ill  = 1'b0;
        res_to   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_ill || req_mis) begin
                        state_d  = ST_DONE;
                        res_load = 1'b1;
                        res_ill  = req_ill;
                        res_mis  = req_mis;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d  = write_q ? ST_DONE : ST_WAIT_R;
                    res_load = write_q;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    state_d  = ST_DONE;
                    res_load = 1'b1;
                    res_data = load_result;
                end else if (wait_expired) begin
                    state_d  = ST_DONE;
                    res_load = 1'b1;
                    res_to   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            rd_q    <= 32'h0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= ALUResult;
                f3_q    <= req_funct3;
                write_q <= req_write;
                wdata_q <= write_data;
            end
            if (res_load) begin
                rd_q  <= res_data;
                mis_q <= res_mis;
                ill_q <= res_ill;
                to_q  <= res_to;
            end
        end
    end

    assign in_access  = (state_q == ST_ACCESS);
    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign read_data  = rd_q;
    assign misaligned = mis_q;
    assign illegal    = ill_q;
    assign timeout    = to_q;

    // Memory-side outputs are forced quiet outside ACCESS so stale payload never leaks.
    assign mem_valid = in_access;
    assign mem_we    = in_access && write_q;
    assign mem_addr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = in_access ? lane_wdata : 32'h0;
    assign mem_be    = in_access ? lane_be : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: vector table plus hand-written
// sequences for memory stall, stray rvalid, reset during WAIT_R and timeout.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] ALUResult, write_data;
    logic        rsp_valid;
    logic [31:0] read_data;
    logic        misaligned, illegal, timeout;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[17];

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .ALUResult  (ALUResult),
        .write_data (write_data),
        .rsp_valid  (rsp_valid),
        .read_data  (read_data),
        .misaligned (misaligned),
        .illegal    (illegal),
        .timeout    (timeout),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request at a negedge; returns after the accepting posedge.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        check("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        ALUResult  = a;
        write_data = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic seen_mem = 1'b0;
        logic rv_sent  = 1'b0;
        logic got      = 1'b0;
        int   lat      = 0;
        mem_ready = 1'b1;
        exp_q.push_back(v.exp_rd);
        issue(v.write, v.f3, v.addr, v.wdata);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (mem_valid) begin
                seen_mem = 1'b1;
                check({v.name, "_mem_addr"}, mem_addr, v.exp_addr);
                check({v.name, "_mem_be"}, {28'h0, mem_be}, {28'h0, v.exp_be});
                check({v.name, "_mem_we"}, {31'h0, mem_we}, {31'h0, v.write});
                if (v.write) check({v.name, "_mem_wdata"}, mem_wdata, v.exp_wdata);
            end else if (seen_mem && !v.write && !rsp_valid && !rv_sent) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rdata;
                rv_sent    = 1'b1;
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
                check({v.name, "_read_data"}, read_data, exp_q.pop_front());
                check({v.name, "_misaligned"}, {31'h0, misaligned}, {31'h0, v.exp_mis});
                check({v.name, "_illegal"}, {31'h0, illegal}, {31'h0, v.exp_ill});
                check({v.name, "_timeout"}, {31'h0, timeout}, 32'h0);
            end
        end
        check({v.name, "_rsp_seen"}, {31'h0, got}, 32'h1);
        check({v.name, "_latency"}, lat, v.exp_lat);
        check({v.name, "_mem_used"}, {31'h0, seen_mem}, {31'h0, v.exp_mem});
        if (got) begin
            @(negedge clk);
            check({v.name, "_rsp_one_cycle"}, {31'h0, rsp_valid}, 32'h0);
            check({v.name, "_read_data_hold"}, read_data, v.exp_rd);
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int pulses;
        int lat;
        logic got;

        //               name    wr  f3      addr        wdata         rdata         mem  exp_addr    be       exp_wdata     exp_rd        mis  ill  lat
        vecs[0]  = '{"sw",    1, 3'b010, 32'h03C0, 32'h00005555, 32'h0,        1, 32'h03C0, 4'b1111, 32'h00005555, 32'h0,        0, 0, 2};
        vecs[1]  = '{"sb3",   1, 3'b000, 32'h0F0F, 32'h000000AA, 32'h0,        1, 32'h0F0C, 4'b1000, 32'hAAAAAAAA, 32'h0,        0, 0, 2};
        vecs[2]  = '{"sh_hi", 1, 3'b001, 32'h0102, 32'h1234BEEF, 32'h0,        1, 32'h0100, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 2};
        vecs[3]  = '{"sh_lo", 1, 3'b001, 32'h0100, 32'h0000CAFE, 32'h0,        1, 32'h0100, 4'b0011, 32'hCAFECAFE, 32'h0,        0, 0, 2};
        vecs[4]  = '{"sb1",   1, 3'b000, 32'h0001, 32'h12345677, 32'h0,        1, 32'h0000, 4'b0010, 32'h77777777, 32'h0,        0, 0, 2};
        vecs[5]  = '{"lb",    0, 3'b000, 32'h0513, 32'h0,        32'h80FF1234, 1, 32'h0510, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0, 3};
        vecs[6]  = '{"lbu",   0, 3'b100, 32'h0513, 32'h0,        32'h80FF1234, 1, 32'h0510, 4'b1111, 32'h0,        32'h00000080, 0, 0, 3};
        vecs[7]  = '{"lhu",   0, 3'b101, 32'h0512, 32'h0,        32'h80FF1234, 1, 32'h0510, 4'b1111, 32'h0,        32'h000080FF, 0, 0, 3};
        vecs[8]  = '{"lh",    0, 3'b001, 32'h0512, 32'h0,        32'h80FF1234, 1, 32'h0510, 4'b1111, 32'h0,        32'hFFFF80FF, 0, 0, 3};
        vecs[9]  = '{"lw",    0, 3'b010, 32'h0200, 32'h0,        32'hDEADBEEF, 1, 32'h0200, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 3};
        vecs[10] = '{"lb0",   0, 3'b000, 32'h0200, 32'h0,        32'h1234567F, 1, 32'h0200, 4'b1111, 32'h0,        32'h0000007F, 0, 0, 3};
        vecs[11] = '{"lh_mis",0, 3'b001, 32'h0001, 32'h0,        32'h0,        0, 32'h0,    4'b0000, 32'h0,        32'h0,        1, 0, 1};
        vecs[12] = '{"ld_ill",0, 3'b011, 32'h0000, 32'h0,        32'h0,        0, 32'h0,    4'b0000, 32'h0,        32'h0,        0, 1, 1};
        vecs[13] = '{"lw_mis",0, 3'b010, 32'h0002, 32'h0,        32'h0,        0, 32'h0,    4'b0000, 32'h0,        32'h0,        1, 0, 1};
        vecs[14] = '{"st_ill",1, 3'b101, 32'h0001, 32'h0,        32'h0,        0, 32'h0,    4'b0000, 32'h0,        32'h0,        0, 1, 1};
        vecs[15] = '{"sw_mis",1, 3'b010, 32'h0006, 32'h0,        32'h0,        0, 32'h0,    4'b0000, 32'h0,        32'h0,        1, 0, 1};
        vecs[16] = '{"lhu_mis",0,3'b101, 32'h0003, 32'h0,        32'h0,        0, 32'h0,    4'b0000, 32'h0,        32'h0,        1, 0, 1};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        ALUResult  = 32'h0;
        write_data = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Memory stall: payload must stay put until mem_ready is seen.
        mem_ready = 1'b0;
        issue(1'b1, 3'b001, 32'h0102, 32'h0000BEEF);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("stall_mem_valid", {31'h0, mem_valid}, 32'h1);
            check("stall_mem_addr", mem_addr, 32'h0100);
            check("stall_mem_be", {28'h0, mem_be}, 32'hC);
            check("stall_mem_wdata", mem_wdata, 32'hBEEFBEEF);
            check("stall_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("stall_mem_valid_off", {31'h0, mem_valid}, 32'h0);

        // Stray rvalid while idle must not produce a response.
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        pulses = 0;
        repeat (3) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        check("stray_rvalid_no_rsp", pulses, 0);
        check("stray_rvalid_rd_hold", read_data, 32'h0);

        // Reset while waiting for load data drops the access.
        issue(1'b0, 3'b010, 32'h0040, 32'h0);
        @(negedge clk);
        check("rstw_access", {31'h0, mem_valid}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstw_req_ready", {31'h0, req_ready}, 32'h1);
        check("rstw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rstw_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rstw_mem_addr", mem_addr, 32'h0);
        check("rstw_read_data", read_data, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid) pulses++;
        end
        check("rstw_no_rsp", pulses, 0);
        check("rstw_read_data_after", read_data, 32'h0);

`ifdef LSU_TIMEOUT_EN
        // ACCESS at N+1, 16 WAIT_R cycles N+2..N+17, DONE at N+18.
        mem_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h0080, 32'h0);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
                check("to_flag", {31'h0, timeout}, 32'h1);
                check("to_read_data", read_data, 32'h0);
            end
        end
        check("to_rsp_seen", {31'h0, got}, 32'h1);
        check("to_latency", lat, 18);
`else
        mem_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h0080, 32'h0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("noto_no_rsp", pulses, 0);
        check("noto_timeout_low", {31'h0, timeout}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("noto_recover_ready", {31'h0, req_ready}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
